// File: rtl/alu_pkg.sv
// Shared types for the pipelined integer ALU.
// funct_t opcodes, request bundle and result-source selector.
package alu_pkg;

  localparam int FUNCT_W    = 4;
  localparam int MAX_DATA_W = 64;
  localparam int MAX_TAG_W  = 32;

  typedef enum logic [FUNCT_W-1:0] {
    FN_ADD  = 4'd0,
    FN_SUB  = 4'd1,
    FN_MUL  = 4'd2,
    FN_MULH = 4'd3,
    FN_MULS = 4'd4,
    FN_AND  = 4'd5,
    FN_OR   = 4'd6,
    FN_XOR  = 4'd7,
    FN_SLL  = 4'd8,
    FN_SRL  = 4'd9,
    FN_SRA  = 4'd10,
    FN_SEQ  = 4'd11,
    FN_SLTU = 4'd12,
    FN_SLTS = 4'd13,
    FN_MUX  = 4'd14,
    FN_ADDC = 4'd15
  } funct_t;

  typedef logic [MAX_DATA_W-1:0] data_t;
  typedef logic [MAX_TAG_W-1:0]  tag_t;

  // Sized for the widest legal build; narrower
  // builds use the low bits of each field.
  typedef struct packed {
    funct_t funct;
    data_t  x;
    data_t  y;
    logic   carry;
    logic   select;
    data_t  mask;
    tag_t   tag;
  } alu_req_t;

  typedef enum logic [1:0] {
    SEL_ALU = 2'd0,
    SEL_LO  = 2'd1,
    SEL_HI  = 2'd2
  } res_sel_t;

  function automatic logic is_arith(funct_t f);
    return f inside {FN_ADD, FN_SUB, FN_ADDC};
  endfunction

endpackage

// File: rtl/alu_mul_stage.sv
// Two-register multiplier (DSP-mappable), signed or unsigned.
// Ports: clock, reset(async low), en, a, b, sgn -> p1 (1st reg), p2 (2nd reg).
module alu_mul_stage
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           en,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           sgn,
  output logic [2*W-1:0] p1,
  output logic [2*W-1:0] p2
);

  logic signed [2*W-1:0] ax;
  logic signed [2*W-1:0] bx;
  logic signed [2*W-1:0] prod;

  // Extend to full product width so one
  // multiplier covers both signednesses.
  always_comb begin
    ax   = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    bx   = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    prod = ax * bx;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p1 <= '0;
      p2 <= '0;
    end else if (en) begin
      p1 <= prod;
      p2 <= p1;
    end
  end

endmodule

// File: rtl/pipelined_alu.sv
// 3-stage integer ALU with ready/valid flow control and tag passthrough.
// Ports: clock, reset(async low), io_in_* request, io_out_* result;
// `define ALU_FLAGS_EN adds io_zero / io_overflow.
module pipelined_alu
  import alu_pkg::*;
#(
  parameter  int DATA_W  = 16,
  parameter  int TAG_W   = 8,
  localparam int SHAMT_W = $clog2(DATA_W)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_in_valid,
  output logic                io_in_ready,
  input  logic [FUNCT_W-1:0]  io_in_funct,
  input  logic [DATA_W-1:0]   io_in_x,
  input  logic [DATA_W-1:0]   io_in_y,
  input  logic                io_in_carry,
  input  logic                io_in_select,
  input  logic [DATA_W-1:0]   io_in_mask,
  input  logic [TAG_W-1:0]    io_in_tag,
  output logic                io_out_valid,
  input  logic                io_out_ready,
  output logic [DATA_W-1:0]   io_out,
  output logic [2*DATA_W-1:0] io_mul_out,
  output logic                io_carry_out,
  output logic [TAG_W-1:0]    io_out_tag
`ifdef ALU_FLAGS_EN
  ,
  output logic                io_zero,
  output logic                io_overflow
`endif
);

  localparam int MSB = DATA_W - 1;

  logic en;
  logic v0, v1, v2;

  // One global enable: everything advances
  // unless the output is held by the consumer.
  assign en           = !v2 || io_out_ready;
  assign io_in_ready  = en;
  assign io_out_valid = v2;

  // S0: input register
  alu_req_t req_d, r0;

  always_comb begin
    req_d                    = '0;
    req_d.funct              = funct_t'(io_in_funct);
    req_d.x[DATA_W-1:0]      = io_in_x;
    req_d.y[DATA_W-1:0]      = io_in_y;
    req_d.carry              = io_in_carry;
    req_d.select             = io_in_select;
    req_d.mask[DATA_W-1:0]   = io_in_mask;
    req_d.tag[TAG_W-1:0]     = io_in_tag;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v0 <= 1'b0;
      r0 <= '0;
    end else if (en) begin
      v0 <= io_in_valid;
      r0 <= req_d;
    end
  end

  // Upper struct bits are constant zero here.
  logic unused_req;
  assign unused_req = ^r0;

  logic [DATA_W-1:0]  x0, y0, m0;
  logic [TAG_W-1:0]   t0;
  logic [SHAMT_W-1:0] sh0;

  assign x0  = r0.x[DATA_W-1:0];
  assign y0  = r0.y[DATA_W-1:0];
  assign m0  = r0.mask[DATA_W-1:0];
  assign t0  = r0.tag[TAG_W-1:0];
  assign sh0 = r0.y[SHAMT_W-1:0];

  // S1: compute
  logic [DATA_W-1:0] yop;
  logic              cin;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] res;
  logic              cy;
  res_sel_t          sel;
  logic              ovf;

  // SUB shares the adder as x + ~y + 1.
  always_comb begin
    yop = (r0.funct == FN_SUB) ? ~y0 : y0;
    cin = 1'b0;
    if (r0.funct == FN_SUB)  cin = 1'b1;
    if (r0.funct == FN_ADDC) cin = r0.carry;
    sum = {1'b0, x0} + {1'b0, yop}
        + {{DATA_W{1'b0}}, cin};
  end

  always_comb begin
    res = '0;
    cy  = 1'b0;
    sel = SEL_ALU;
    unique case (r0.funct)
      FN_ADD, FN_SUB, FN_ADDC: begin
        res = sum[DATA_W-1:0];
        cy  = sum[DATA_W];
      end
      FN_MUL:  sel = SEL_LO;
      FN_MULH: sel = SEL_HI;
      FN_MULS: sel = SEL_HI;
      FN_AND:  res = x0 & y0;
      FN_OR:   res = x0 | y0;
      FN_XOR:  res = x0 ^ y0;
      FN_SLL:  res = x0 << sh0;
      FN_SRL:  res = x0 >> sh0;
      FN_SRA:  res = $signed(x0) >>> sh0;
      FN_SEQ:  res = {{MSB{1'b0}}, x0 == y0};
      FN_SLTU: res = {{MSB{1'b0}}, x0 < y0};
      FN_SLTS: res = {{MSB{1'b0}},
                      $signed(x0) < $signed(y0)};
      FN_MUX:  res = r0.select ? y0 : x0;
      default: res = '0;
    endcase
  end

  // Signed overflow on the shared adder:
  // like-signed operands, result sign differs.
  always_comb begin
    ovf = 1'b0;
    if (is_arith(r0.funct))
      ovf = (x0[MSB] == yop[MSB])
         && (sum[MSB] != x0[MSB]);
  end

  logic [2*DATA_W-1:0] p1;

  alu_mul_stage #(
    .W (DATA_W)
  ) u_mul (
    .clock (clock),
    .reset (reset),
    .en    (en),
    .a     (x0),
    .b     (y0),
    .sgn   (r0.funct == FN_MULS),
    .p1    (p1),
    .p2    (io_mul_out)
  );

  logic [DATA_W-1:0] res1, m1;
  logic [TAG_W-1:0]  t1;
  logic              cy1;
  res_sel_t          sel1;
  logic              ovf1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1   <= 1'b0;
      res1 <= '0;
      m1   <= '0;
      t1   <= '0;
      cy1  <= 1'b0;
      sel1 <= SEL_ALU;
      ovf1 <= 1'b0;
    end else if (en) begin
      v1   <= v0;
      res1 <= res;
      m1   <= m0;
      t1   <= t0;
      cy1  <= cy;
      sel1 <= sel;
      ovf1 <= ovf;
    end
  end

  // S2: result select, mask, output register
  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] out_d;

  always_comb begin
    raw = res1;
    unique case (sel1)
      SEL_LO:  raw = p1[DATA_W-1:0];
      SEL_HI:  raw = p1[2*DATA_W-1:DATA_W];
      default: raw = res1;
    endcase
    out_d = raw & m1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v2           <= 1'b0;
      io_out       <= '0;
      io_carry_out <= 1'b0;
      io_out_tag   <= '0;
    end else if (en) begin
      v2           <= v1;
      io_out       <= out_d;
      io_carry_out <= cy1;
      io_out_tag   <= t1;
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_zero     <= 1'b0;
      io_overflow <= 1'b0;
    end else if (en) begin
      io_zero     <= (out_d == '0);
      io_overflow <= ovf1;
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = ovf1;
`endif

endmodule

// File: tb/tb_pipelined_alu.sv
// Testbench for pipelined_alu: directed literals plus random traffic
// against a behavioural model; 16-bit and 32-bit instances.
module tb_pipelined_alu;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // 16-bit instance
  logic        iv, ir, ov, ordy, c, s, co;
  logic [3:0]  f;
  logic [15:0] x, y, m, o;
  logic [31:0] mo;
  logic [7:0]  tg, ot;
`ifdef ALU_FLAGS_EN
  logic        zf, vf;
`endif

  pipelined_alu #(.DATA_W(16), .TAG_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (iv),
    .io_in_ready  (ir),
    .io_in_funct  (f),
    .io_in_x      (x),
    .io_in_y      (y),
    .io_in_carry  (c),
    .io_in_select (s),
    .io_in_mask   (m),
    .io_in_tag    (tg),
    .io_out_valid (ov),
    .io_out_ready (ordy),
    .io_out       (o),
    .io_mul_out   (mo),
    .io_carry_out (co),
    .io_out_tag   (ot)
`ifdef ALU_FLAGS_EN
    ,
    .io_zero      (zf),
    .io_overflow  (vf)
`endif
  );

  // 32-bit instance
  logic        iv32, ir32, ov32, ordy32, c32, s32, co32;
  logic [3:0]  f32;
  logic [31:0] x32, y32, m32, o32;
  logic [63:0] mo32;
  logic [7:0]  tg32, ot32;
`ifdef ALU_FLAGS_EN
  logic        zf32, vf32;
`endif

  pipelined_alu #(.DATA_W(32), .TAG_W(8)) dut32 (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (iv32),
    .io_in_ready  (ir32),
    .io_in_funct  (f32),
    .io_in_x      (x32),
    .io_in_y      (y32),
    .io_in_carry  (c32),
    .io_in_select (s32),
    .io_in_mask   (m32),
    .io_in_tag    (tg32),
    .io_out_valid (ov32),
    .io_out_ready (ordy32),
    .io_out       (o32),
    .io_mul_out   (mo32),
    .io_carry_out (co32),
    .io_out_tag   (ot32)
`ifdef ALU_FLAGS_EN
    ,
    .io_zero      (zf32),
    .io_overflow  (vf32)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm,
                     input longint unsigned act,
                     input longint unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    longint unsigned o;
    longint unsigned mul;
    bit              c;
    logic [7:0]      tag;
    bit              z;
    bit              v;
  } exp_t;

  // Reference model from the opcode definitions.
  function automatic exp_t model(
    input int W, input logic [3:0] fn,
    input longint unsigned a, input longint unsigned b,
    input bit ci, input bit sl,
    input longint unsigned mk, input logic [7:0] t);
    exp_t e;
    longint unsigned wm, m2;
    longint sa, sb, sum, lim;
    int sh;
    bit ar;
    wm  = (64'd1 << W) - 1;
    m2  = (W >= 32) ? '1 : (64'd1 << (2 * W)) - 1;
    sa  = $signed(a << (64 - W)) >>> (64 - W);
    sb  = $signed(b << (64 - W)) >>> (64 - W);
    sh  = int'(b % longint'(W));
    lim = 64'sd1 <<< (W - 1);
    e.mul = (a * b) & m2;
    e.c = 0; e.v = 0; e.tag = t;
    e.o = 0; sum = 0; ar = 0;
    case (fn)
      4'd0:  begin e.o = a + b; e.c = ((a + b) >> W) != 0;
                   sum = sa + sb; ar = 1; end
      4'd1:  begin e.o = a - b; e.c = a >= b;
                   sum = sa - sb; ar = 1; end
      4'd2:  e.o = a * b;
      4'd3:  e.o = (a * b) >> W;
      4'd4:  begin e.mul = longint'(sa * sb) & m2;
                   e.o = e.mul >> W; end
      4'd5:  e.o = a & b;
      4'd6:  e.o = a | b;
      4'd7:  e.o = a ^ b;
      4'd8:  e.o = a << sh;
      4'd9:  e.o = a >> sh;
      4'd10: e.o = longint'(sa >>> sh);
      4'd11: e.o = (a == b) ? 1 : 0;
      4'd12: e.o = (a < b) ? 1 : 0;
      4'd13: e.o = (sa < sb) ? 1 : 0;
      4'd14: e.o = sl ? b : a;
      default: begin
        e.o = a + b + longint'(ci);
        e.c = ((a + b + longint'(ci)) >> W) != 0;
        sum = sa + sb + longint'(ci); ar = 1;
      end
    endcase
    e.o = e.o & wm & mk;
    e.z = (e.o == 0);
    if (ar) e.v = (sum >= lim) || (sum < -lim);
    return e;
  endfunction

  // Compare process on the 16-bit instance.
  exp_t q[$];
  exp_t ef;
  logic [7:0] seen[$];
  int popped = 0;
  bit stall_prev = 0;
  logic [15:0] h_o;
  logic [31:0] h_mo;
  logic [7:0]  h_t;

  always @(negedge clock) begin
    if (!reset) begin
      chk("rst_valid", ov, 0);
      chk("rst_outs", {o, mo, co, ot}, 0);
      q.delete();
      stall_prev = 0;
    end else begin
      chk("in_ready", ir, !ov || ordy);
      if (stall_prev)
        chk("hold", {o, mo, ot}, {h_o, h_mo, h_t});
      if (ov) begin
        if (q.size() == 0) begin
          chk("stale_q", q.size(), 1);
        end else begin
          ef = q[0];
          chk("out", o, ef.o);
          chk("mul", mo, ef.mul);
          chk("carry", co, ef.c);
          chk("tag", ot, ef.tag);
`ifdef ALU_FLAGS_EN
          chk("zero", zf, ef.z);
          chk("ovf", vf, ef.v);
`endif
          if (ordy) begin
            void'(q.pop_front());
            seen.push_back(ot);
            popped++;
          end
        end
      end
      stall_prev = ov && !ordy;
      h_o = o; h_mo = mo; h_t = ot;
      if (iv && ir)
        q.push_back(model(16, f, x, y, c, s, m, tg));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Single op into an empty 16-bit pipe; checks
  // latency, literals and the model itself.
  task automatic dir16(input string nm,
    input logic [3:0] fn, input logic [15:0] a,
    input logic [15:0] b, input logic [15:0] mk,
    input logic [15:0] eo, input logic [31:0] em,
    input logic ec);
    exp_t e;
    e = model(16, fn, a, b, 0, 0, mk, 8'hA5);
    chk({nm, "_model"}, e.o, eo);
    iv = 1; f = fn; x = a; y = b; c = 0; s = 0;
    m = mk; tg = 8'hA5; ordy = 1;
    tick();
    iv = 0;
    @(negedge clock); chk({nm, "_lat1"}, ov, 0);
    @(negedge clock); chk({nm, "_lat2"}, ov, 0);
    @(negedge clock); chk({nm, "_lat3"}, ov, 1);
    chk({nm, "_out"}, o, eo);
    chk({nm, "_mul"}, mo, em);
    chk({nm, "_carry"}, co, ec);
    tick();
  endtask

  task automatic dir32(input string nm,
    input logic [3:0] fn, input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] eo,
    input logic [63:0] em, input logic ec);
    exp_t e;
    e = model(32, fn, a, b, 0, 0, 32'hFFFF_FFFF, 8'h5A);
    chk({nm, "_model"}, e.o, eo);
    iv32 = 1; f32 = fn; x32 = a; y32 = b;
    c32 = 0; s32 = 0; m32 = '1; tg32 = 8'h5A;
    tick();
    iv32 = 0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk({nm, "_valid"}, ov32, 1);
    chk({nm, "_out"}, o32, eo);
    chk({nm, "_mul"}, mo32, em);
    chk({nm, "_carry"}, co32, ec);
    chk({nm, "_tag"}, ot32, 8'h5A);
    tick();
  endtask

  task automatic rand_fields();
    f  = 4'($urandom_range(0, 15));
    x  = 16'($urandom);
    y  = 16'($urandom);
    c  = 1'($urandom);
    s  = 1'($urandom);
    m  = ($urandom_range(0, 1) == 1) ? 16'hFFFF
                                     : 16'($urandom);
    tg = 8'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, nval, acc_n, cyc;
    bit acc;
    iv = 0; ordy = 1; f = 0; x = 0; y = 0;
    c = 0; s = 0; m = 0; tg = 0;
    iv32 = 0; ordy32 = 1; f32 = 0; x32 = 0; y32 = 0;
    c32 = 0; s32 = 0; m32 = 0; tg32 = 0;
    repeat (3) tick();
    chk("rst32", {ov32, o32, mo32, co32, ot32}, 0);
    reset = 1;
    tick();

    dir16("add_wrap", 4'd0, 16'hFFFF, 16'h0001,
          16'hFFFF, 16'h0000, 32'h0000_FFFF, 1'b1);
    dir16("muls", 4'd4, 16'hFFFE, 16'h0003,
          16'hFFFF, 16'hFFFF, 32'hFFFF_FFFA, 1'b0);
    dir16("mulh", 4'd3, 16'hFFFE, 16'h0003,
          16'hFFFF, 16'h0002, 32'h0002_FFFA, 1'b0);
    dir16("sra", 4'd10, 16'h8000, 16'h0013,
          16'hFFFF, 16'hF000, 32'h0009_8000, 1'b0);
    dir16("sra_mask", 4'd10, 16'h8000, 16'h0013,
          16'h00FF, 16'h0000, 32'h0009_8000, 1'b0);
    dir32("sub32", 4'd1, 32'h1, 32'h2,
          32'hFFFF_FFFF, 64'h2, 1'b0);
    dir32("slts32", 4'd13, 32'h8000_0000, 32'h1,
          32'h1, 64'h8000_0000, 1'b0);

    // Back-pressure: 5 ADDs, consumer stalls cycles 4..7
    seen.delete();
    sent = 0;
    for (int k = 0; k < 16; k++) begin
      ordy = !(k >= 4 && k <= 7);
      if (sent < 5) begin
        iv = 1; f = 4'd0; x = 16'($urandom);
        y = 16'($urandom); m = 16'hFFFF;
        tg = 8'(sent + 1);
      end else begin
        iv = 0;
      end
      @(negedge clock);
      acc = iv && ir;
      if (k >= 4 && k <= 7)
        chk("bp_stall_ready", ir, 0);
      tick();
      if (acc) sent++;
    end
    chk("bp_count", seen.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < seen.size())
        chk("bp_order", seen[i], i + 1);

    // Reset with three ops in flight
    ordy = 1;
    for (int k = 0; k < 3; k++) begin
      iv = 1; rand_fields();
      tick();
    end
    iv = 0;
    reset = 0;
    #1;
    chk("rst_imm_valid", ov, 0);
    tick();
    reset = 1;
    nval = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (ov) nval++;
      tick();
    end
    chk("no_stale", nval, 0);

    // Random traffic
    acc_n = 0; cyc = 0;
    while (acc_n < 2000 && cyc < 20000) begin
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 3) != 0);
      rand_fields();
      @(negedge clock);
      if (iv && ir) acc_n++;
      tick();
      cyc++;
    end
    chk("rand_count", acc_n, 2000);

    iv = 0; ordy = 1;
    for (int k = 0; k < 50; k++) begin
      if (q.size() == 0 && !ov) break;
      tick();
    end
    chk("drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
